// File: rtl/time_set_if.sv
// Front-panel bus between the time-setting controller and its neighbours:
// raw buttons in, hold/step/clear/mode outputs to the counter stage.
interface time_set_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] hold;
  logic       min_step;
  logic       sec_clr;
  logic [1:0] set_mode;

  modport master (output btn_mode, btn_inc,
                  input  hold, min_step, sec_clr, set_mode);
  modport slave  (input  btn_mode, btn_inc,
                  output hold, min_step, sec_clr, set_mode);
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced MODE/INC buttons drive a RUN/SET_HR/SET_MIN/SET_SEC
// FSM that emits hold codes and one-cycle step/clear pulses, with INC auto-repeat and idle timeout.
module tsc_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          s1_q, s2_q, db_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign db_o = db_q;
endmodule

module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic        clk,
  input logic        rst_n,
  time_set_if.slave  bus
);
  localparam int NUM_BTN  = 2;
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int RW       = $clog2(REPEAT_DELAY) + 1;
  localparam int TW       = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

  logic [NUM_BTN-1:0] raw, db, db_prev_q, press;
  logic [RW-1:0]      rep_cnt_q;
  logic [TW-1:0]      idle_q;
  logic               rep_fire, any_press, inc_evt, timeout;
  state_t             state_q, state_nxt;
  logic [2:0]         hold_q;
  logic               min_step_q, sec_clr_q;

  assign raw = {bus.btn_inc, bus.btn_mode};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    tsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (raw[g]),
      .db_o  (db[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_prev_q <= '0;
    else        db_prev_q <= db;
  end

  assign press = db & ~db_prev_q;

  // rep_cnt counts cycles since the db rise; after each repeat it is rewound so the
  // next hit of REPEAT_DELAY lands exactly REPEAT_PERIOD cycles later.
  assign rep_fire = db[BTN_INC] && (rep_cnt_q == RW'(REPEAT_DELAY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rep_cnt_q <= '0;
    else if (!db[BTN_INC]) rep_cnt_q <= '0;
    else if (rep_fire)     rep_cnt_q <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    else                   rep_cnt_q <= rep_cnt_q + 1'b1;
  end

  function automatic logic [2:0] hold_code(state_t s);
    case (s)
      SET_HR:  return 3'b001;
      SET_MIN: return 3'b010;
      SET_SEC: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  assign state_nxt = state_t'(state_q + 2'd1);
  assign any_press = press[BTN_MODE] | press[BTN_INC] | rep_fire;
  // A mode press in the same cycle swallows the inc event entirely.
  assign inc_evt   = (press[BTN_INC] | rep_fire) & ~press[BTN_MODE] & (state_q != RUN);
  assign timeout   = (state_q != RUN) && !any_press && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      hold_q     <= 3'b000;
      min_step_q <= 1'b0;
      sec_clr_q  <= 1'b0;
      idle_q     <= '0;
    end else begin
      min_step_q <= 1'b0;
      sec_clr_q  <= 1'b0;
      hold_q     <= hold_code(state_q);

      if (state_q == RUN || any_press || timeout) idle_q <= '0;
      else                                         idle_q <= idle_q + 1'b1;

      if (press[BTN_MODE]) begin
        state_q <= state_nxt;
        hold_q  <= hold_code(state_nxt);
      end else if (timeout) begin
        state_q <= RUN;
        hold_q  <= 3'b000;
      end else if (inc_evt) begin
        case (state_q)
          SET_HR:  hold_q     <= 3'b101;
          SET_MIN: min_step_q <= 1'b1;
          SET_SEC: sec_clr_q  <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.hold     = hold_q;
  assign bus.min_step = min_step_q;
  assign bus.sec_clr  = sec_clr_q;
  assign bus.set_mode = state_q;
endmodule
